// File: rtl/wordexp_64_if.sv
// Handshake bundle for wordexp_64: operand in, Montgomery-domain result out.
interface wordexp_64_if #(
  parameter int O_SIZE = 64
);
  logic [46:0]       qH;
  logic [O_SIZE-1:0] A;
  logic              in_valid;
  logic              in_ready;
  logic [O_SIZE-1:0] T;
  logic              out_valid;
  logic              out_ready;
  logic              err;

  modport master (
    output qH, A, in_valid, out_ready,
    input  in_ready, T, out_valid, err
  );

  modport slave (
    input  qH, A, in_valid, out_ready,
    output in_ready, T, out_valid, err
  );
endinterface

// File: rtl/wordexp_64.sv
// Bit-serial A*2^(17*K_WORDS) mod q, q = {qH,17'h00001}.
// Optional range check of A against q: WORDEXP_RANGE_CHECK_EN.
module wordexp_64 #(
  parameter int K_WORDS = 4,
  parameter int O_SIZE  = 64
) (
  input logic         clk,
  input logic         rst,
  wordexp_64_if.slave bus
);
  localparam int N_STEPS = 17 * K_WORDS;
  localparam int CW      = $clog2(N_STEPS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            r_state;
  logic [64:0]       r_acc;
  logic [63:0]       r_q;
  logic [CW-1:0]     r_cnt;
  logic [O_SIZE-1:0] r_T;
  logic              r_in_ready;
  logic              r_out_valid;

  logic [65:0]       w_dbl;
  logic [65:0]       w_q66;
  logic [65:0]       w_nxt;
  logic              w_accept;
  logic              w_last;
  logic              w_unused;

  assign w_dbl    = {r_acc, 1'b0};
  assign w_q66    = {2'b00, r_q};
  assign w_nxt    = (w_dbl >= w_q66) ? (w_dbl - w_q66) : w_dbl;
  assign w_accept = (r_state == IDLE) && r_in_ready && bus.in_valid;
  assign w_last   = (r_cnt == CW'(N_STEPS - 1));
  assign w_unused = w_nxt[65];

`ifdef WORDEXP_RANGE_CHECK_EN
  logic r_err;
  logic r_oor;
  logic w_oor;

  assign w_oor   = 65'(bus.A) >= 65'({bus.qH, 17'h00001});
  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_T         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef WORDEXP_RANGE_CHECK_EN
      r_err       <= 1'b0;
      r_oor       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_q        <= {bus.qH, 17'h00001};
            r_acc      <= 65'(bus.A);
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
`ifdef WORDEXP_RANGE_CHECK_EN
            r_oor      <= w_oor;
`endif
          end
        end
        RUN: begin
          r_acc <= w_nxt[64:0];
          r_cnt <= r_cnt + 1'b1;
`ifdef WORDEXP_RANGE_CHECK_EN
          // Out-of-range operand bypasses the doubling loop
          if (r_oor) begin
            r_T         <= '0;
            r_err       <= 1'b1;
            r_oor       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else
`endif
          if (w_last) begin
            r_T         <= w_nxt[O_SIZE-1:0];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
`ifdef WORDEXP_RANGE_CHECK_EN
            r_err       <= 1'b0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.T         = r_T;
endmodule
